// File: rtl/toggle_event_decoder_if.sv
// Consumer-side handshake bundle for toggle_event_decoder.
// The decoder drives the pending-event view (master); the consumer drives evt_ready (slave).
interface toggle_event_decoder_if #(
  parameter int DEPTH = 8
) ();
  localparam int PEND_W = $clog2(DEPTH + 1);

  logic              evt_valid;
  logic              evt_ready;
  logic [PEND_W-1:0] pend_cnt;

  modport master (
    output evt_valid,
    output pend_cnt,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  pend_cnt,
    output evt_ready
  );
endinterface

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: turns level changes of a remote T-ff output back into one-cycle
// event pulses, queues them as a saturating pending count drained over valid/ready, and
// keeps a wrapping total counter plus a sticky overflow flag for debug.
// Optional build macro TOGGLE_DEC_SYNC_EN: insert a 2-flop synchronizer ahead of the
// edge detector for an asynchronous tog_in (one extra cycle of latency, 2-edge INIT).
module toggle_event_decoder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tog_in,
  output logic                   evt_pulse,
  output logic [CNT_W-1:0]       evt_total,
  output logic                   overflow,
  input  logic                   clr_ovf,
  toggle_event_decoder_if.master evt_if
);

  localparam int PEND_W = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef TOGGLE_DEC_SYNC_EN
  localparam int N_SYNC = 2;
`else
  localparam int N_SYNC = 1;
`endif

  logic [0:0]        state_q;
  logic              init_cnt_q;
  logic              samp_in;
  logic              s_p1;
  logic              prev_p2;
  logic              det;
  logic              acc;
  logic              pop;
  logic [PEND_W-1:0] pend_q;

  // Saturating pending-count update; a pop never happens at zero because it needs evt_valid.
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cur,
                                                  input logic a, input logic p);
    logic [PEND_W-1:0] nxt;
    nxt = cur;
    if (a && !p) begin
      if (cur < PEND_W'(DEPTH)) nxt = cur + 1'b1;
    end else if (!a && p) begin
      nxt = cur - 1'b1;
    end
    return nxt;
  endfunction

  // Sticky overflow: a dropped event wins over a clear in the same cycle.
  function automatic logic ovf_next(input logic cur, input logic a, input logic p,
                                    input logic [PEND_W-1:0] cnt, input logic clr);
    logic nxt;
    if (a && !p && (cnt == PEND_W'(DEPTH))) nxt = 1'b1;
    else if (clr)                           nxt = 1'b0;
    else                                    nxt = cur;
    return nxt;
  endfunction

  // ---- stage p0: optional synchronizer front end ----
`ifdef TOGGLE_DEC_SYNC_EN
  logic s1_p0;

  // First synchronizer flop for the asynchronous link input.
  always_ff @(posedge clk) begin
    if (reset) s1_p0 <= 1'b0;
    else       s1_p0 <= tog_in;
  end

  assign samp_in = s1_p0;
`else
  assign samp_in = tog_in;
`endif

  // ---- stage p1/p2: sample and previous-sample registers ----
  // During INIT prev is loaded with the same value as s so the idle link level
  // present at reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_p1    <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      s_p1    <= samp_in;
      prev_p2 <= (state_q == ST_INIT) ? samp_in : s_p1;
    end
  end

  assign det = s_p1 ^ prev_p2;
  assign acc = det && (state_q == ST_RUN);
  assign pop = evt_if.evt_valid && evt_if.evt_ready;

  // Start-up FSM: stay in INIT for N_SYNC edges while the sample chain fills, then RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= 1'b0;
    end else if (state_q == ST_INIT) begin
      if (init_cnt_q == 1'(N_SYNC - 1)) state_q <= ST_RUN;
      else                              init_cnt_q <= init_cnt_q + 1'b1;
    end
  end

  // ---- stage p3: event pulse, queue, counters ----
  // Event outputs, pending queue, total counter and overflow flag update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_pulse <= 1'b0;
      pend_q    <= '0;
      evt_total <= '0;
      overflow  <= 1'b0;
    end else begin
      evt_pulse <= acc;
      pend_q    <= pend_next(pend_q, acc, pop);
      overflow  <= ovf_next(overflow, acc, pop, pend_q, clr_ovf);
      if (acc) evt_total <= evt_total + CNT_W'(1);
    end
  end

  assign evt_if.pend_cnt  = pend_q;
  assign evt_if.evt_valid = (pend_q != '0);

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder: a vector table for the steady-state checks
// plus hand-written sequences for pulse latency, same-edge pop/event and reset corners.
module tb_toggle_event_decoder;

`ifdef TOGGLE_DEC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tog_in = 1'b1;
  logic        evt_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        evt_pulse;
  logic [15:0] evt_total;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  toggle_event_decoder_if #(.DEPTH(8)) evt_if ();
  assign evt_if.evt_ready = evt_ready;

  toggle_event_decoder #(.DEPTH(8), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .tog_in    (tog_in),
    .evt_pulse (evt_pulse),
    .evt_total (evt_total),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .evt_if    (evt_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (evt_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

  typedef struct {
    logic  rst;
    logic  tog;
    logic  rdy;
    logic  clr;
    int    cyc;
    int    np;
    int    pend;
    int    valid;
    int    ovf;
    int    total;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic tog, input logic rdy, input logic clr,
                     input int cyc, input int np, input int pend, input int valid,
                     input int ovf, input int total, input string name);
    vec_t v;
    v.rst = rst; v.tog = tog; v.rdy = rdy; v.clr = clr; v.cyc = cyc; v.np = np;
    v.pend = pend; v.valid = valid; v.ovf = ovf; v.total = total; v.name = name;
    vecs.push_back(v);
  endtask

  // Toggle the link, then assert ready/clear for exactly the edge that registers the event.
  task automatic edge_event(input logic rdy_e, input logic clr_e);
    tog_in = ~tog_in;
    repeat (LAT - 1) tick();
    evt_ready = rdy_e;
    clr_ovf   = clr_e;
    tick();
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  initial begin
    int np0;

    // rst tog rdy clr cyc np pend valid ovf total
    add(1, 1, 0, 0, 3, 0, 0, 0, 0, 0, "reset_hold");
    add(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, "init_no_event");
    add(0, 0, 0, 0, 4, 1, 1, 1, 0, 1, "tog1");
    add(0, 1, 0, 0, 4, 1, 2, 1, 0, 2, "tog2");
    add(0, 0, 0, 0, 4, 1, 3, 1, 0, 3, "tog3");
    add(0, 0, 1, 0, 1, 0, 2, 1, 0, 3, "pop1");
    add(0, 0, 1, 0, 1, 0, 1, 1, 0, 3, "pop2");
    add(0, 0, 1, 0, 1, 0, 0, 0, 0, 3, "pop3");
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 3, "pop_empty");
    for (int k = 1; k <= 10; k++)
      add(0, logic'(k % 2), 0, 0, 4, 1, (k < 8) ? k : 8, 1, (k >= 9) ? 1 : 0, 3 + k,
          $sformatf("fill%0d", k));
    add(0, 0, 0, 1, 1, 0, 8, 1, 0, 13, "clr_ovf");

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      tog_in    = vecs[i].tog;
      evt_ready = vecs[i].rdy;
      clr_ovf   = vecs[i].clr;
      np0 = pulse_cnt;
      repeat (vecs[i].cyc) tick();
      chk({vecs[i].name, "_pulses"}, pulse_cnt - np0, vecs[i].np);
      chk({vecs[i].name, "_pend"}, int'(evt_if.pend_cnt), vecs[i].pend);
      chk({vecs[i].name, "_valid"}, int'(evt_if.evt_valid), vecs[i].valid);
      chk({vecs[i].name, "_ovf"}, int'(overflow), vecs[i].ovf);
      chk({vecs[i].name, "_total"}, int'(evt_total), vecs[i].total);
    end
    clr_ovf = 1'b0;

    // 11th event while full, clear asserted on the same edge: set wins
    edge_event(1'b0, 1'b1);
    chk("ovf_set_vs_clr_pulse", int'(evt_pulse), 1);
    chk("ovf_set_vs_clr", int'(overflow), 1);
    chk("ovf_set_vs_clr_pend", int'(evt_if.pend_cnt), 8);
    chk("ovf_set_vs_clr_total", int'(evt_total), 14);
    tick();
    chk("ovf_sticky", int'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);

    // Full queue, pop on the event edge: accepted, no overflow
    edge_event(1'b1, 1'b0);
    chk("full_pop_evt_pulse", int'(evt_pulse), 1);
    chk("full_pop_evt_pend", int'(evt_if.pend_cnt), 8);
    chk("full_pop_evt_ovf", int'(overflow), 0);
    chk("full_pop_evt_total", int'(evt_total), 15);

    evt_ready = 1'b1;
    repeat (8) tick();
    evt_ready = 1'b0;
    chk("drain_pend", int'(evt_if.pend_cnt), 0);
    chk("drain_valid", int'(evt_if.evt_valid), 0);

    // Pulse latency and width
    tog_in = ~tog_in;
    for (int i = 1; i < LAT; i++) begin
      tick();
      chk($sformatf("lat_pre%0d", i), int'(evt_pulse), 0);
    end
    tick();
    chk("lat_pulse", int'(evt_pulse), 1);
    tick();
    chk("lat_post", int'(evt_pulse), 0);
    chk("lat_pend", int'(evt_if.pend_cnt), 1);
    chk("lat_total", int'(evt_total), 16);

    // Same-edge pop and event with two pending
    tog_in = ~tog_in;
    repeat (LAT + 1) tick();
    chk("pre_accpop_pend", int'(evt_if.pend_cnt), 2);
    edge_event(1'b1, 1'b0);
    chk("accpop_pulse", int'(evt_pulse), 1);
    chk("accpop_pend", int'(evt_if.pend_cnt), 2);
    chk("accpop_total", int'(evt_total), 18);
    tick();
    chk("accpop_hold", int'(evt_if.pend_cnt), 2);

    // Wrap of the total counter with a continuous toggle burst
    reset = 1'b1;
    tick();
    tick();
    chk("rst2_pend", int'(evt_if.pend_cnt), 0);
    chk("rst2_total", int'(evt_total), 0);
    tog_in = 1'b0;
    reset  = 1'b0;
    repeat (3) tick();
    evt_ready = 1'b1;
    np0 = pulse_cnt;
    for (int i = 0; i < 65537; i++) begin
      tog_in = ~tog_in;
      tick();
    end
    repeat (LAT + 2) tick();
    evt_ready = 1'b0;
    chk("burst_pulses", pulse_cnt - np0, 65537);
    chk("burst_total_wrap", int'(evt_total), 1);
    chk("burst_pend", int'(evt_if.pend_cnt), 0);

    for (int i = 0; i < 5; i++) begin
      tog_in = ~tog_in;
      repeat (4) tick();
    end
    chk("pre_rst_pend", int'(evt_if.pend_cnt), 5);
    chk("pre_rst_total", int'(evt_total), 6);

    // Reset with an event in flight and the link resting at 1
    tog_in = ~tog_in;
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_pulse", int'(evt_pulse), 0);
    chk("midrst_pend", int'(evt_if.pend_cnt), 0);
    chk("midrst_valid", int'(evt_if.evt_valid), 0);
    chk("midrst_total", int'(evt_total), 0);
    chk("midrst_ovf", int'(overflow), 0);
    reset = 1'b0;
    np0 = pulse_cnt;
    repeat (6) tick();
    chk("post_rst_level", int'(tog_in), 1);
    chk("post_rst_pulses", pulse_cnt - np0, 0);
    chk("post_rst_pend", int'(evt_if.pend_cnt), 0);
    chk("post_rst_total", int'(evt_total), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
